// File: rtl/memory_loader_ram.sv
// Single-port RAM that zeroes itself after reset, then accepts a bulk load from a
// streaming loader before handing the array over to a CPU port.
module memory_loader_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] d_o,
  output logic              rd_valid,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              busy,
  output logic [ADDR_W:0]   load_count
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [ADDR_W:0]   count_nxt;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  // All three modes share one write port; the mode selects its source.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave one unassigned (no latches).
    state_nxt = state;
    ptr_nxt   = ptr;
    count_nxt = load_count;
    mem_we    = 1'b0;
    mem_addr  = addr;
    mem_wdata = d_i;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = ptr;
        mem_wdata = '0;
        if (&ptr) begin
          state_nxt = LOAD;
          ptr_nxt   = '0;
          count_nxt = '0;
        end else begin
          ptr_nxt = ptr + ADDR_W'(1);
        end
      end
      LOAD: begin
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_addr  = ptr;
          mem_wdata = load_data;
          count_nxt = load_count + (ADDR_W+1)'(1);
          // The top address ends the load as well; ptr is never allowed to wrap.
          if (load_last || (&ptr)) state_nxt = RUN;
          else                     ptr_nxt   = ptr + ADDR_W'(1);
        end
      end
      RUN: begin
        mem_we = we;
        if (load_start) begin
          state_nxt = LOAD;
          ptr_nxt   = '0;
          count_nxt = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign load_ready = (state == LOAD);
  assign busy       = (state != RUN);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      ptr        <= '0;
      load_count <= '0;
      d_o        <= '0;
      rd_valid   <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      load_count <= count_nxt;
      rd_valid   <= (state == RUN);
      if (state == RUN) d_o <= mem[addr];
    end
  end

  // NOTE: the array has no reset; CLEAR zeroes it after every reset instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

endmodule

// File: tb/tb_memory_loader_ram.sv
// Randomised bench for memory_loader_ram: a mode-level reference model is compared
// against the DUT every cycle, plus literal checks for the directed scenarios.
module tb_memory_loader_ram;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [7:0] addr;
  logic [7:0] d_i;
  logic [7:0] d_o;
  logic       rd_valid;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       busy;
  logic [8:0] load_count;

  memory_loader_ram #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .d_i(d_i), .d_o(d_o),
    .rd_valid(rd_valid), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .busy(busy), .load_count(load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the memory and outputs must be, one step per clock edge.
  typedef enum {M_CLEAR, M_LOAD, M_RUN} mode_t;
  mode_t      m_mode;
  int         m_ptr, m_count;
  logic [7:0] m_mem [256];
  logic [7:0] m_do;
  logic       m_rdv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_CLEAR; m_ptr <= 0; m_count <= 0; m_do <= 8'h00; m_rdv <= 1'b0;
    end else begin
      m_rdv <= (m_mode == M_RUN);
      case (m_mode)
        M_CLEAR: begin
          m_mem[m_ptr] <= 8'h00;
          if (m_ptr == 255) begin m_mode <= M_LOAD; m_ptr <= 0; m_count <= 0; end
          else m_ptr <= m_ptr + 1;
        end
        M_LOAD: if (load_valid) begin
          m_mem[m_ptr] <= load_data;
          m_count <= m_count + 1;
          if (load_last || m_ptr == 255) m_mode <= M_RUN;
          else m_ptr <= m_ptr + 1;
        end
        M_RUN: begin
          m_do <= m_mem[addr];
          if (we) m_mem[addr] <= d_i;
          if (load_start) begin m_mode <= M_LOAD; m_ptr <= 0; m_count <= 0; end
        end
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n && cmp_en) begin
      check("busy",       32'(busy),       32'(m_mode != M_RUN));
      check("load_ready", 32'(load_ready), 32'(m_mode == M_LOAD));
      check("load_count", 32'(load_count), 32'(m_count));
      check("rd_valid",   32'(rd_valid),   32'(m_rdv));
      check("d_o",        32'(d_o),        32'(m_do));
    end
  end

  logic [7:0] ld_buf [256];

  task automatic set_idle;
    we = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic wait_load_ready(input int exp_cycles, input string name);
    int n = 0;
    while (!load_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check(name, 32'(n), 32'(exp_cycles));
  endtask

  // Streams ld_buf[0..n-1]; invalid cycles carry junk, including a stray load_last.
  task automatic load_words(input int n, input bit use_last, input bit toggle);
    int i = 0;
    int k = 0;
    while (i < n && k < 4000) begin
      @(negedge clk);
      load_valid = toggle ? (k % 2 == 0) : ($urandom_range(0, 3) != 0);
      load_data  = load_valid ? ld_buf[i] : 8'($urandom);
      load_last  = load_valid ? (use_last && i == n - 1) : 1'($urandom_range(0, 1));
      load_start = 1'($urandom_range(0, 1));
      we         = 1'($urandom_range(0, 1));
      addr       = 8'($urandom);
      d_i        = 8'($urandom);
      if (load_valid && load_ready) i++;
      k++;
    end
    @(negedge clk);
    set_idle();
  endtask

  task automatic read_chk(input logic [7:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    set_idle();
    addr = a;
    @(posedge clk); #1;
    check(name, 32'(d_o), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    rst_n = 1'b0; addr = 8'h00; d_i = 8'h00; load_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst busy",       32'(busy),       32'd1);
    check("rst load_ready", 32'(load_ready), 32'd0);
    check("rst d_o",        32'(d_o),        32'd0);
    check("rst rd_valid",   32'(rd_valid),   32'd0);
    check("rst load_count", 32'(load_count), 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    wait_load_ready(256, "clear cycles");
    check("count after clear", 32'(load_count), 32'd0);

    // Six-word load with toggling valid, terminated by load_last.
    ld_buf[0] = 8'h64; ld_buf[1] = 8'h10; ld_buf[2] = 8'h93;
    ld_buf[3] = 8'h58; ld_buf[4] = 8'hFF; ld_buf[5] = 8'h05;
    load_words(6, 1'b1, 1'b1);
    check("load6 count", 32'(load_count), 32'd6);
    check("load6 busy",  32'(busy),       32'd0);
    read_chk(8'h00, 8'h64, "rd 00");
    read_chk(8'h01, 8'h10, "rd 01");
    read_chk(8'h02, 8'h93, "rd 02");
    read_chk(8'h03, 8'h58, "rd 03");
    read_chk(8'h04, 8'hFF, "rd 04");
    read_chk(8'h05, 8'h05, "rd 05");
    read_chk(8'h06, 8'h00, "rd 06");
    check("run rd_valid", 32'(rd_valid), 32'd1);

    // Read-before-write on the same address.
    @(negedge clk);
    addr = 8'h10; we = 1'b1; d_i = 8'hA5;
    @(posedge clk); #1;
    check("rbw old", 32'(d_o), 32'h00);
    read_chk(8'h10, 8'hA5, "rbw new");

    // load_start with a simultaneous CPU write.
    @(negedge clk);
    load_start = 1'b1; we = 1'b1; addr = 8'h20; d_i = 8'h7E;
    @(negedge clk);
    set_idle();
    check("ls load_ready", 32'(load_ready), 32'd1);
    check("ls load_count", 32'(load_count), 32'd0);
    ld_buf[0] = 8'h11; ld_buf[1] = 8'h22;
    load_words(2, 1'b1, 1'b0);
    check("ls count", 32'(load_count), 32'd2);
    read_chk(8'h00, 8'h11, "ls rd 00");
    read_chk(8'h01, 8'h22, "ls rd 01");
    read_chk(8'h02, 8'h93, "ls rd 02");
    read_chk(8'h05, 8'h05, "ls rd 05");
    read_chk(8'h10, 8'hA5, "ls rd 10");
    read_chk(8'h20, 8'h7E, "ls rd 20");

    // Random CPU traffic, checked by the model each cycle.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      we = 1'($urandom_range(0, 1)); addr = 8'($urandom); d_i = 8'($urandom);
    end
    @(negedge clk);
    set_idle();

    // Full-depth load without load_last.
    for (int i = 0; i < 256; i++) ld_buf[i] = 8'($urandom);
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    set_idle();
    load_words(256, 1'b0, 1'b0);
    check("full count", 32'(load_count), 32'd256);
    check("full busy",  32'(busy),       32'd0);
    read_chk(8'h00, ld_buf[0],   "full rd 00");
    read_chk(8'hFF, ld_buf[255], "full rd FF");
    check("full count held", 32'(load_count), 32'd256);

    // Reset in the middle of a load.
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    set_idle();
    ld_buf[0] = 8'hC1; ld_buf[1] = 8'hC2; ld_buf[2] = 8'hC3;
    load_words(3, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst busy",       32'(busy),       32'd1);
    check("mid rst load_ready", 32'(load_ready), 32'd0);
    check("mid rst d_o",        32'(d_o),        32'd0);
    check("mid rst rd_valid",   32'(rd_valid),   32'd0);
    check("mid rst load_count", 32'(load_count), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_load_ready(256, "reclear cycles");
    ld_buf[0] = 8'h3C;
    load_words(1, 1'b1, 1'b0);
    read_chk(8'h00, 8'h3C, "post rst rd 00");
    read_chk(8'h01, 8'h00, "post rst rd 01");
    read_chk(8'h02, 8'h00, "post rst rd 02");
    read_chk(8'h20, 8'h00, "post rst rd 20");
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      addr = 8'(a);
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
